// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 decoder: FSM encoding, prefix and key
// codes, and the event / modifier records carried between stages.
package ps2_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_E0    = 3'd1;
    localparam logic [2:0] S_F0    = 3'd2;
    localparam logic [2:0] S_E0F0  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_ALT    = 8'h11;
    localparam logic [7:0] KEY_CAPS   = 8'h58;
    localparam logic [7:0] KEY_PAUSE  = 8'h77;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic       pause;
        logic [7:0] ascii;
    } ps2_event_t;

    typedef struct packed {
        logic lshift;
        logic rshift;
        logic lctrl;
        logic rctrl;
        logic lalt;
        logic ralt;
    } mod_t;

    // Keyboard status/acknowledge bytes that carry no key information.
    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_discard = 1'b1;
            default:                                   is_discard = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 scan code to ASCII translation for non-extended codes; letters follow
// the upper input, everything without a printable mapping yields 0x00.
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       upper,
    output logic [7:0] ascii
);

    logic [7:0] base;

    always_comb begin
        // NOTE: each combinational block assigns every output up front, so no path leaves a value unassigned and no latch is inferred.
        base = 8'h00;
        case (code)
            8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
            8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
            8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
            8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
            8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
            8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
            8'h35: base = "y";  8'h1A: base = "z";
            8'h45: base = "0";  8'h16: base = "1";  8'h1E: base = "2";  8'h26: base = "3";
            8'h25: base = "4";  8'h2E: base = "5";  8'h36: base = "6";  8'h3D: base = "7";
            8'h3E: base = "8";  8'h46: base = "9";
            8'h29: base = 8'h20;
            8'h5A: base = 8'h0D;
            8'h66: base = 8'h08;
            8'h0D: base = 8'h09;
            8'h76: base = 8'h1B;
            default: base = 8'h00;
        endcase

        if (ext) begin
            ascii = 8'h00;
        end else if (upper && base >= "a" && base <= "z") begin
            ascii = base - 8'h20;
        end else begin
            ascii = base;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 decoder: pops receiver bytes, parses E0/F0/E1 prefixes and emits one
// registered key event per action with modifier, Caps Lock, repeat and ASCII state.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PAUSE_LEN = 7
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    output logic             kbd_nextdata_n,
    output logic             ev_valid,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_repeat,
    output logic             ev_pause,
    output logic [7:0]       ev_ascii,
    output logic             mod_shift,
    output logic             mod_ctrl,
    output logic             mod_alt,
    output logic             caps_lock,
    output logic [CNT_W-1:0] make_count
);

    localparam int PW = $clog2(PAUSE_LEN + 1);

    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    pause_cnt_q, pause_cnt_d;
    logic             held_valid_q, held_valid_d;
    logic [8:0]       held_key_q, held_key_d;
    mod_t             mods_q, mods_d;
    logic             caps_q, caps_d;
    logic [CNT_W-1:0] make_count_q, make_count_d;
    logic             ev_valid_q, ev_valid_d;
    ps2_event_t       ev_q, ev_d;

    logic       emit, emit_ext, emit_brk, emit_pause, is_rep;
    logic [8:0] key;
    logic [7:0] lut_ascii;

    // The receiver advances on the same edge we sample, so ready held high streams one byte per cycle.
    assign kbd_nextdata_n = ~kbd_ready;

    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        emit        = 1'b0;
        emit_ext    = 1'b0;
        emit_brk    = 1'b0;
        emit_pause  = 1'b0;
        if (kbd_ready) begin
            case (state_q)
                S_IDLE: begin
                    if (kbd_data == PS2_EXT) begin
                        state_d = S_E0;
                    end else if (kbd_data == PS2_BRK) begin
                        state_d = S_F0;
                    end else if (kbd_data == PS2_PAUSE) begin
                        state_d     = S_PAUSE;
                        pause_cnt_d = PW'(PAUSE_LEN);
                    end else if (!is_discard(kbd_data)) begin
                        emit = 1'b1;
                    end
                end
                S_E0: begin
                    if (kbd_data == PS2_BRK) begin
                        state_d = S_E0F0;
                    end else if (kbd_data != PS2_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_F0: begin
                    if (kbd_data != PS2_BRK) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_E0F0: begin
                    emit     = 1'b1;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                    state_d  = S_IDLE;
                end
                S_PAUSE: begin
                    pause_cnt_d = pause_cnt_q - PW'(1);
                    if (pause_cnt_q <= PW'(1)) begin
                        emit       = 1'b1;
                        emit_pause = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ASCII sees the modifier state from before this event is applied.
    ps2_ascii_lut u_ascii_lut (
        .code  (kbd_data),
        .ext   (emit_ext),
        .upper ((mods_q.lshift | mods_q.rshift) ^ caps_q),
        .ascii (lut_ascii)
    );

    always_comb begin
        ev_valid_d   = emit;
        ev_d         = ev_q;
        held_valid_d = held_valid_q;
        held_key_d   = held_key_q;
        mods_d       = mods_q;
        caps_d       = caps_q;
        make_count_d = make_count_q;
        key          = {emit_ext, kbd_data};
        is_rep       = emit & ~emit_brk & ~emit_pause & held_valid_q & (held_key_q == key);

        if (emit) begin
            ev_d.code  = emit_pause ? KEY_PAUSE : kbd_data;
            ev_d.ext   = emit_ext;
            ev_d.brk   = emit_brk;
            ev_d.rep   = is_rep;
            ev_d.pause = emit_pause;
            ev_d.ascii = emit_pause ? 8'h00 : lut_ascii;
        end

        if (emit && !emit_pause) begin
            if (emit_brk) begin
                if (held_valid_q && held_key_q == key) begin
                    held_valid_d = 1'b0;
                end
            end else if (!is_rep) begin
                held_valid_d = 1'b1;
                held_key_d   = key;
                make_count_d = make_count_q + CNT_W'(1);
                if (key == {1'b0, KEY_CAPS}) begin
                    caps_d = ~caps_q;
                end
            end

            case (key)
                {1'b0, KEY_LSHIFT}: mods_d.lshift = ~emit_brk;
                {1'b0, KEY_RSHIFT}: mods_d.rshift = ~emit_brk;
                {1'b0, KEY_CTRL}:   mods_d.lctrl  = ~emit_brk;
                {1'b1, KEY_CTRL}:   mods_d.rctrl  = ~emit_brk;
                {1'b0, KEY_ALT}:    mods_d.lalt   = ~emit_brk;
                {1'b1, KEY_ALT}:    mods_d.ralt   = ~emit_brk;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            pause_cnt_q  <= '0;
            held_valid_q <= 1'b0;
            held_key_q   <= '0;
            mods_q       <= '0;
            caps_q       <= 1'b0;
            make_count_q <= '0;
            ev_valid_q   <= 1'b0;
            ev_q         <= '0;
        end else begin
            state_q      <= state_d;
            pause_cnt_q  <= pause_cnt_d;
            held_valid_q <= held_valid_d;
            held_key_q   <= held_key_d;
            mods_q       <= mods_d;
            caps_q       <= caps_d;
            make_count_q <= make_count_d;
            ev_valid_q   <= ev_valid_d;
            ev_q         <= ev_d;
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_code    = ev_q.code;
    assign ev_ext     = ev_q.ext;
    assign ev_break   = ev_q.brk;
    assign ev_repeat  = ev_q.rep;
    assign ev_pause   = ev_q.pause;
    assign ev_ascii   = ev_q.ascii;
    assign mod_shift  = mods_q.lshift | mods_q.rshift;
    assign mod_ctrl   = mods_q.lctrl | mods_q.rctrl;
    assign mod_alt    = mods_q.lalt | mods_q.ralt;
    assign caps_lock  = caps_q;
    assign make_count = make_count_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios plus a random byte stream,
// all compared cycle by cycle against a prefix-flag reference model.
module tb_ps2_scancode_decoder;

    typedef logic [7:0] bq_t[$];

    localparam int CNT_W     = 8;
    localparam int PAUSE_LEN = 7;

    logic             clk = 1'b0;
    logic             clrn;
    logic [7:0]       kbd_data;
    logic             kbd_ready;
    logic             kbd_nextdata_n;
    logic             ev_valid;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic             ev_repeat;
    logic             ev_pause;
    logic [7:0]       ev_ascii;
    logic             mod_shift;
    logic             mod_ctrl;
    logic             mod_alt;
    logic             caps_lock;
    logic [CNT_W-1:0] make_count;

    int errors = 0;
    int checks = 0;

    ps2_scancode_decoder #(.CNT_W(CNT_W), .PAUSE_LEN(PAUSE_LEN)) dut (
        .clk            (clk),
        .clrn           (clrn),
        .kbd_data       (kbd_data),
        .kbd_ready      (kbd_ready),
        .kbd_nextdata_n (kbd_nextdata_n),
        .ev_valid       (ev_valid),
        .ev_code        (ev_code),
        .ev_ext         (ev_ext),
        .ev_break       (ev_break),
        .ev_repeat      (ev_repeat),
        .ev_pause       (ev_pause),
        .ev_ascii       (ev_ascii),
        .mod_shift      (mod_shift),
        .mod_ctrl       (mod_ctrl),
        .mod_alt        (mod_alt),
        .caps_lock      (caps_lock),
        .make_count     (make_count)
    );

    always #5 clk = ~clk;

    // Reference model: letters/digits as lookup tables, prefixes as two flags plus a pause byte budget.
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    bit         m_pext, m_pbrk, m_held_v;
    int         m_pause_left, m_count;
    logic [8:0] m_held;
    bit         m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral, m_caps;
    bit         m_valid, m_ext, m_brk, m_rep, m_pause;
    logic [7:0] m_code, m_ascii;

    task automatic model_reset();
        m_pext = 0; m_pbrk = 0; m_held_v = 0; m_pause_left = 0; m_count = 0; m_held = '0;
        m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_lal = 0; m_ral = 0; m_caps = 0;
        m_valid = 0; m_ext = 0; m_brk = 0; m_rep = 0; m_pause = 0; m_code = '0; m_ascii = '0;
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit upper);
        for (int i = 0; i < 26; i++)
            if (letters[i] == c) return (upper ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == c) return 8'h30 + 8'(i);
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h0D:   return 8'h09;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input logic [7:0] b);
        bit         emit = 0, e = 0, k = 0, p = 0;
        logic [7:0] c = b;
        logic [8:0] key;
        m_valid = 0;
        if (m_pause_left > 0) begin
            m_pause_left--;
            if (m_pause_left == 0) begin emit = 1; p = 1; c = 8'h77; end
        end else if (!m_pext && !m_pbrk && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        end else if (!m_pbrk && b == 8'hE0) begin
            m_pext = 1;
        end else if (!m_pbrk && b == 8'hF0) begin
            m_pbrk = 1;
        end else if (m_pbrk && !m_pext && b == 8'hF0) begin
        end else if (!m_pext && !m_pbrk && b == 8'hE1) begin
            m_pause_left = PAUSE_LEN;
        end else begin
            emit = 1; e = m_pext; k = m_pbrk; m_pext = 0; m_pbrk = 0;
        end

        if (emit) begin
            key     = {e, c};
            m_valid = 1;
            m_rep   = !p && !k && m_held_v && (m_held == key);
            m_code  = c; m_ext = e; m_brk = k; m_pause = p;
            m_ascii = (p || e) ? 8'h00 : ref_ascii(c, (m_lsh | m_rsh) ^ m_caps);
            if (!p) begin
                if (!k) begin
                    if (!m_rep) begin
                        m_held_v = 1; m_held = key; m_count++;
                        if (key == 9'h058) m_caps = !m_caps;
                    end
                end else if (m_held_v && m_held == key) begin
                    m_held_v = 0;
                end
                if (key == 9'h012) m_lsh = !k;
                if (key == 9'h059) m_rsh = !k;
                if (key == 9'h014) m_lct = !k;
                if (key == 9'h114) m_rct = !k;
                if (key == 9'h011) m_lal = !k;
                if (key == 9'h111) m_ral = !k;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        kbd_ready = 0;
        clrn      = 0;
        @(negedge clk);
        clrn = 1;
        model_reset();
    endtask

    // Drives a byte stream (optionally with idle gaps) and compares every cycle against the model.
    task automatic run_stream(input string name, input bq_t q, input bit gaps,
                              output int nev, output bq_t asc);
        int         i = 0;
        bit         idle;
        logic [24:0] got_ev, exp_ev;
        nev = 0;
        asc = {};
        while (i <= q.size()) begin
            idle = (i == q.size()) || (gaps && $urandom_range(0, 3) == 0);
            @(negedge clk);
            kbd_ready = !idle;
            if (!idle) kbd_data = q[i];
            #1;
            checks++;
            if (kbd_nextdata_n !== idle) begin
                errors++;
                $display("FAIL %s pop_strobe step %0d: got %b exp %b", name, i, kbd_nextdata_n, idle);
            end
            @(posedge clk);
            #1;
            if (idle) m_valid = 0;
            else model_step(q[i]);
            got_ev = {ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_pause, ev_ascii};
            exp_ev = {m_valid, m_code, m_ext, m_brk, m_rep, m_pause, m_ascii};
            checks++;
            if (got_ev !== exp_ev) begin
                errors++;
                $display("FAIL %s event step %0d: got %h exp %h", name, i, got_ev, exp_ev);
            end
            checks++;
            if ({mod_shift, mod_ctrl, mod_alt, caps_lock} !==
                {m_lsh | m_rsh, m_lct | m_rct, m_lal | m_ral, m_caps}) begin
                errors++;
                $display("FAIL %s mods step %0d: got %b exp %b", name, i,
                         {mod_shift, mod_ctrl, mod_alt, caps_lock},
                         {m_lsh | m_rsh, m_lct | m_rct, m_lal | m_ral, m_caps});
            end
            checks++;
            if (make_count !== CNT_W'(m_count)) begin
                errors++;
                $display("FAIL %s make_count step %0d: got %0d exp %0d", name, i, make_count, CNT_W'(m_count));
            end
            if (ev_valid === 1'b1) begin
                nev++;
                asc.push_back(ev_ascii);
            end
            if (idle && i == q.size()) break;
            if (!idle) i++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_pause, ev_ascii,
             mod_shift, mod_ctrl, mod_alt, caps_lock, make_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero event/mod/count state, ev_code=%h count=%0d", ev_code, make_count);
        end
        checks++;
        if (kbd_nextdata_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_pop: got %b exp 1", kbd_nextdata_n);
        end
        @(negedge clk);
        clrn = 1;
        model_reset();
    endtask

    task automatic test_make();
        bq_t s, asc;
        int  nev;
        do_reset();
        s = '{8'h1C};
        run_stream("make", s, 0, nev, asc);
        checks++;
        if (nev !== 1 || ev_code !== 8'h1C || ev_ascii !== 8'h61 || ev_break !== 1'b0 || make_count !== 8'd1) begin
            errors++;
            $display("FAIL make_1c: got nev=%0d code=%h ascii=%h brk=%b cnt=%0d exp 1/1c/61/0/1",
                     nev, ev_code, ev_ascii, ev_break, make_count);
        end
    endtask

    task automatic test_break();
        bq_t s, asc;
        int  nev;
        do_reset();
        s = '{8'h1C, 8'hF0, 8'h1C};
        run_stream("break", s, 0, nev, asc);
        checks++;
        if (nev !== 2 || ev_break !== 1'b1 || ev_ascii !== 8'h61 || make_count !== 8'd1) begin
            errors++;
            $display("FAIL break_1c: got nev=%0d brk=%b ascii=%h cnt=%0d exp 2/1/61/1",
                     nev, ev_break, ev_ascii, make_count);
        end
        s = '{8'hF0};
        run_stream("f0_alone", s, 0, nev, asc);
        checks++;
        if (nev !== 0) begin
            errors++;
            $display("FAIL f0_alone_events: got %0d exp 0", nev);
        end
    endtask

    task automatic test_shift_caps();
        bq_t s, asc;
        int  nev;
        do_reset();
        s = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C};
        run_stream("shift_caps", s, 1, nev, asc);
        checks++;
        if (nev !== 8 || asc[1] !== 8'h41 || asc[5] !== 8'h41 || asc[7] !== 8'h61) begin
            errors++;
            $display("FAIL shift_caps_ascii: got nev=%0d a1=%h a5=%h a7=%h exp 8/41/41/61",
                     nev, asc[1], asc[5], asc[7]);
        end
        checks++;
        if (caps_lock !== 1'b1 || mod_shift !== 1'b1 || make_count !== 8'd6) begin
            errors++;
            $display("FAIL shift_caps_state: got caps=%b shift=%b cnt=%0d exp 1/1/6", caps_lock, mod_shift, make_count);
        end
    endtask

    task automatic test_ext();
        bq_t s, asc;
        int  nev;
        do_reset();
        s = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        run_stream("ext", s, 0, nev, asc);
        checks++;
        if (nev !== 2 || ev_ext !== 1'b1 || ev_break !== 1'b1 || ev_ascii !== 8'h00 ||
            {mod_shift, mod_ctrl, mod_alt} !== 3'b000) begin
            errors++;
            $display("FAIL ext_75: got nev=%0d ext=%b brk=%b ascii=%h mods=%b exp 2/1/1/00/000",
                     nev, ev_ext, ev_break, ev_ascii, {mod_shift, mod_ctrl, mod_alt});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            kbd_data  = 8'h1C;
            kbd_ready = 1;
            #1;
            checks++;
            if (kbd_nextdata_n !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pop %0d: got %b exp 0", k, kbd_nextdata_n);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ev_valid !== 1'b1 || ev_repeat !== (k > 0)) begin
                errors++;
                $display("FAIL b2b_event %0d: got valid=%b rep=%b exp 1/%b", k, ev_valid, ev_repeat, k > 0);
            end
        end
        @(negedge clk);
        kbd_ready = 0;
        @(posedge clk);
        #1;
        checks++;
        if (ev_valid !== 1'b0 || make_count !== 8'd1) begin
            errors++;
            $display("FAIL b2b_tail: got valid=%b cnt=%0d exp 0/1", ev_valid, make_count);
        end
    endtask

    task automatic test_pause();
        bq_t s, asc;
        int  nev;
        do_reset();
        s = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        run_stream("pause", s, 1, nev, asc);
        checks++;
        if (nev !== 1 || ev_pause !== 1'b1 || ev_code !== 8'h77 || ev_break !== 1'b0 || make_count !== 8'd0) begin
            errors++;
            $display("FAIL pause_seq: got nev=%0d pause=%b code=%h brk=%b cnt=%0d exp 1/1/77/0/0",
                     nev, ev_pause, ev_code, ev_break, make_count);
        end
    endtask

    task automatic test_reset_mid();
        bq_t s, asc;
        int  nev;
        do_reset();
        s = '{8'h1C, 8'hE0};
        run_stream("mid_pre", s, 0, nev, asc);
        @(negedge clk);
        #2 clrn = 0;
        #1;
        checks++;
        if (make_count !== '0 || ev_code !== 8'h00 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got cnt=%0d code=%h valid=%b exp 0/00/0", make_count, ev_code, ev_valid);
        end
        @(negedge clk);
        clrn = 1;
        model_reset();
        s = '{8'h1C};
        run_stream("mid_post", s, 0, nev, asc);
        checks++;
        if (nev !== 1 || ev_ext !== 1'b0 || ev_code !== 8'h1C || make_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_reset_make: got nev=%0d ext=%b code=%h cnt=%0d exp 1/0/1c/1",
                     nev, ev_ext, ev_code, make_count);
        end
    endtask

    task automatic test_random();
        bq_t        s, asc;
        int         nev;
        logic [7:0] pool [26] = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h45,
                                  8'h16, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h75, 8'hE0, 8'hE0,
                                  8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'hE1, 8'h77, 8'h1A};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) s.push_back(8'($urandom_range(0, 255)));
            else s.push_back(pool[$urandom_range(0, 25)]);
        end
        run_stream("random", s, 1, nev, asc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn      = 0;
        kbd_ready = 0;
        kbd_data  = 8'h00;
        model_reset();
        test_reset();
        test_make();
        test_break();
        test_shift_caps();
        test_ext();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream from the PS/2 keyboard receiver FIFO and turns it into key events.
- Drives the FIFO pop strobe and parses set-2 prefixes (E0 extended, F0 break, E1 pause).
- Tracks modifier, Caps Lock and auto-repeat state, and emits one registered event per key action with ASCII translation.
- Sits between the PS/2 receiver and the display/console logic.

Parameters:
- CNT_W, 8, width of the make-event counter (wraps).
- PAUSE_LEN, 7, bytes following E1 that are swallowed as the Pause sequence.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- kbd_data  in  8  receiver head byte, valid while kbd_ready=1
- kbd_ready  in  1  receiver FIFO non-empty
- kbd_nextdata_n  out  1  active-low pop strobe to receiver
- ev_valid  out  1  one-cycle event pulse
- ev_code  out  8  scan code of event
- ev_ext  out  1  code was E0-prefixed
- ev_break  out  1  1=release, 0=press
- ev_repeat  out  1  press is auto-repeat of held key
- ev_pause  out  1  event is the Pause key
- ev_ascii  out  8  ASCII of ev_code, 0x00 if none
- mod_shift, mod_ctrl, mod_alt  out  1 each  live modifier state
- caps_lock  out  1  Caps Lock toggle state
- make_count  out  CNT_W  non-repeat press count

Behaviour:
- Reset: clk and async active-low clrn only; clrn=0 clears everything immediately. All outputs 0, kbd_nextdata_n=1, FSM in S_IDLE, held-key register invalid, pause counter 0.
- Reset mid-sequence discards any partial prefix.
Pop handshake:
- kbd_nextdata_n = ~kbd_ready (combinational). A byte is accepted on every rising edge where kbd_ready=1.
- The receiver advances on that same edge, so back-to-back bytes are accepted one per cycle with no stall.
FSM (state updates on each accepted byte):
- S_IDLE: E0->S_E0; F0->S_F0; E1->S_PAUSE (counter=PAUSE_LEN); AA/FA/EE/FE/00/FF discarded, stay; other -> make event ext=0.
- S_E0: F0->S_E0F0; E0 stays; other -> make event ext=1, ->S_IDLE.
- S_F0: F0 stays; other -> break event ext=0, ->S_IDLE.
- S_E0F0: any byte -> break event ext=1, ->S_IDLE.
- S_PAUSE: decrement per byte. On reaching 0, emit event ev_pause=1, ev_code=0x77, ev_break=0, ev_ext=0; ->S_IDLE.
Event outputs:
- Registered: byte accepted at edge t produces ev_valid=1 during cycle t+1.
- ev_* fields hold their values until the next event; ev_valid is 0 otherwise.
Repeat suppression:
- held = {ext, code}, with a valid bit.
- Make equal to a valid held key -> ev_repeat=1; no count change; no Caps toggle.
- Make of a different key -> held updated, ev_repeat=0.
- Break matching held -> held invalid. Break of any other key leaves held unchanged.
Modifiers (updated on the event edge, so visible together with ev_valid):
- mod_shift = Lshift(12) | Rshift(59).
- mod_ctrl = Lctrl(14) | Rctrl(E0 14).
- mod_alt = Lalt(11) | Ralt(E0 11).
- Each source is set on make and cleared on break.
- caps_lock toggles on a non-repeat make of 58.
Counting:
- make_count increments on each non-repeat, non-pause make.
- Wraps 2^CNT_W-1 -> 0.
ASCII (ext=0 only; ext=1 -> 0x00, including breaks):
- Standard set-2 letters: lowercase, or uppercase when mod_shift XOR caps_lock.
- Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9' (shift ignored).
- 29->0x20, 5A->0x0D, 66->0x08, 0D->0x09, 76->0x1B.
- ASCII is computed using modifier state before the current event is applied.

Decomposition:
- Package ps2_pkg:
  - FSM state enum.
  - Prefix constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1.
  - Modifier codes, discard-code list.
  - Event struct {code, ext, brk, rep, pause, ascii}.
- Sub-module ps2_ascii_lut: combinational; inputs code, ext, upper; output ascii.

Test Plan:
- Reset, then 1C -> ev_valid one cycle after accept; code=1C, ascii=0x61, break=0, make_count=1.
- 1C, F0, 1C -> second event has break=1, ascii=0x61; make_count stays 1; F0 alone emits no event.
- 12, 1C, F0 12, 58, F0 58, 1C -> events show ascii 0x41 then 0x41. After 12 pressed again, 1C -> 0x61; caps_lock=1.
- E0 75 then E0 F0 75 -> ext=1 make then ext=1 break, ascii=0x00; mod state unchanged.
- 1C 1C 1C (kbd_ready held high, three bytes back-to-back) -> three consecutive ev_valid pulses; repeat=0,1,1; make_count +1; kbd_nextdata_n low three cycles.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event with ev_pause=1. Also: clrn low while in S_E0, then 1C -> ext=0 make.
